// File: rtl/music_box_mode_arbiter_if.sv
// Bundles the per-mode request/bus inputs and the shared SDRAM/DAC/status outputs.
// The arbiter connects through the slave modport and its driver through the master modport.
interface music_box_mode_arbiter_if #(
  parameter int NUM_MODES   = 4,
  parameter int AUDIO_WIDTH = 8,
  parameter int ADDR_WIDTH  = 25,
  parameter int DATA_WIDTH  = 16
) ();
  localparam int SW = $clog2(NUM_MODES + 1) + 1;

  logic [NUM_MODES-1:0]             request_n;
  logic                             abort_n;
  logic [NUM_MODES-1:0]             mode_complete;
  logic [NUM_MODES*AUDIO_WIDTH-1:0] mode_audio;
  logic [NUM_MODES*ADDR_WIDTH-1:0]  mode_sdram_address;
  logic [NUM_MODES*DATA_WIDTH-1:0]  mode_sdram_writeData;
  logic [NUM_MODES-1:0]             mode_sdram_isWriting;
  logic [NUM_MODES-1:0]             mode_sdram_inputValid;

  logic [ADDR_WIDTH-1:0]            sdram_inputAddress;
  logic [DATA_WIDTH-1:0]            sdram_writeData;
  logic                             sdram_isWriting;
  logic                             sdram_inputValid;
  logic [SW-1:0]                    outputState;
  logic [NUM_MODES-1:0]             mode_enable;
  logic                             in_holdoff;
  logic [AUDIO_WIDTH-1:0]           outputAudio;

  modport master (
    output request_n, abort_n, mode_complete, mode_audio,
           mode_sdram_address, mode_sdram_writeData, mode_sdram_isWriting, mode_sdram_inputValid,
    input  sdram_inputAddress, sdram_writeData, sdram_isWriting, sdram_inputValid,
           outputState, mode_enable, in_holdoff, outputAudio
  );

  modport slave (
    input  request_n, abort_n, mode_complete, mode_audio,
           mode_sdram_address, mode_sdram_writeData, mode_sdram_isWriting, mode_sdram_inputValid,
    output sdram_inputAddress, sdram_writeData, sdram_isWriting, sdram_inputValid,
           outputState, mode_enable, in_holdoff, outputAudio
  );
endinterface

// File: rtl/music_box_mode_arbiter.sv
// Arbitrates NUM_MODES button-selected modes, tracks the active one through completion,
// holdoff and rearm, and muxes its SDRAM bus and audio onto the shared controller and DAC.
module music_box_mode_arbiter #(
  parameter int NUM_MODES      = 4,
  parameter int AUDIO_WIDTH    = 8,
  parameter int ADDR_WIDTH     = 25,
  parameter int DATA_WIDTH     = 16,
  parameter int HOLDOFF_CYCLES = 32,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int MIX_ALL        = 0
) (
  input  logic                      clock_50Mhz,
  input  logic                      reset,
  music_box_mode_arbiter_if.slave   bus
);
  localparam int IW   = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;
  localparam int SW   = $clog2(NUM_MODES + 1) + 1;
  localparam int HW   = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam int WW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int SUMW = AUDIO_WIDTH + $clog2(NUM_MODES);
  localparam int WD_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_CYCLES - 1);
  localparam logic [WW-1:0] WD_LAST   = WW'(WD_LAST_I);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_HOLDOFF = 2'd2,
    ST_ERROR   = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          active_q, active_d;
  logic                   rearm_q, rearm_d;
  logic [HW-1:0]          hold_cnt_q, hold_cnt_d;
  logic [WW-1:0]          wd_cnt_q, wd_cnt_d;
  logic [NUM_MODES-1:0]   enable_q, enable_d;
  logic [SW-1:0]          state_out_q, state_out_d;
  logic                   holdoff_q, holdoff_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic                   wr_q, wr_d;
  logic                   valid_q, valid_d;
  logic [AUDIO_WIDTH-1:0] audio_q, audio_d;
  logic                   fwd_s;

  function automatic logic [IW-1:0] pick_highest(input logic [NUM_MODES-1:0] req_n);
    logic [IW-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_MODES; i++) begin
      if (!req_n[i]) idx = IW'(i);
    end
    return idx;
  endfunction

  function automatic logic [AUDIO_WIDTH-1:0] sat_mix(input logic [NUM_MODES*AUDIO_WIDTH-1:0] a);
    logic [SUMW-1:0] s;
    s = '0;
    for (int i = 0; i < NUM_MODES; i++) begin
      s = s + SUMW'(a[i*AUDIO_WIDTH +: AUDIO_WIDTH]);
    end
    if ((s >> AUDIO_WIDTH) != '0) return '1;
    else                          return s[AUDIO_WIDTH-1:0];
  endfunction

  // Next-state, counters and the registered output values.
  always_comb begin
    state_d    = state_q;
    active_d   = active_q;
    rearm_d    = rearm_q;
    hold_cnt_d = hold_cnt_q;
    wd_cnt_d   = wd_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (rearm_q && !(&bus.request_n)) begin
          state_d  = ST_ACTIVE;
          active_d = pick_highest(bus.request_n);
          rearm_d  = 1'b0;
          wd_cnt_d = '0;
        end else if (&bus.request_n) begin
          rearm_d = 1'b1;
        end else begin
          rearm_d = rearm_q;
        end
      end
      ST_ACTIVE: begin
        if (bus.mode_complete[active_q] || !bus.abort_n) begin
          state_d    = ST_HOLDOFF;
          hold_cnt_d = '0;
        end else if (WD_EN && (wd_cnt_q == WD_LAST)) begin
          state_d = ST_ERROR;
        end else if (WD_EN) begin
          wd_cnt_d = wd_cnt_q + WW'(32'd1);
        end else begin
          wd_cnt_d = wd_cnt_q;
        end
      end
      ST_HOLDOFF: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d    = ST_IDLE;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(32'd1);
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d == ST_ACTIVE) enable_d = NUM_MODES'(32'd1) << active_d;
    else                      enable_d = '0;

    case (state_d)
      ST_ACTIVE: state_out_d = SW'(active_d) + SW'(32'd1);
      ST_ERROR:  state_out_d = {1'b1, {(SW-1){1'b0}}};
      default:   state_out_d = '0;
    endcase

    holdoff_d = (state_d == ST_HOLDOFF);

    // Forward the bus of the mode enabled this cycle, but blank it on the edge that enters ERROR.
    fwd_s = (state_q == ST_ACTIVE) && (state_d != ST_ERROR);
    if (fwd_s) begin
      addr_d  = bus.mode_sdram_address[int'(active_q)*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_d = bus.mode_sdram_writeData[int'(active_q)*DATA_WIDTH +: DATA_WIDTH];
      wr_d    = bus.mode_sdram_isWriting[active_q];
      valid_d = bus.mode_sdram_inputValid[active_q];
    end else begin
      addr_d  = '0;
      wdata_d = '0;
      wr_d    = 1'b0;
      valid_d = 1'b0;
    end

    if (MIX_ALL != 0) begin
      if (state_d == ST_ERROR) audio_d = '0;
      else                     audio_d = sat_mix(bus.mode_audio);
    end else if (fwd_s) begin
      audio_d = bus.mode_audio[int'(active_q)*AUDIO_WIDTH +: AUDIO_WIDTH];
    end else begin
      audio_d = '0;
    end
  end

  // State, counters and every output register, with synchronous reset.
  always_ff @(posedge clock_50Mhz) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      active_q    <= '0;
      rearm_q     <= 1'b0;
      hold_cnt_q  <= '0;
      wd_cnt_q    <= '0;
      enable_q    <= '0;
      state_out_q <= '0;
      holdoff_q   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      valid_q     <= 1'b0;
      audio_q     <= '0;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      rearm_q     <= rearm_d;
      hold_cnt_q  <= hold_cnt_d;
      wd_cnt_q    <= wd_cnt_d;
      enable_q    <= enable_d;
      state_out_q <= state_out_d;
      holdoff_q   <= holdoff_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      valid_q     <= valid_d;
      audio_q     <= audio_d;
    end
  end

  assign bus.mode_enable        = enable_q;
  assign bus.outputState        = state_out_q;
  assign bus.in_holdoff         = holdoff_q;
  assign bus.sdram_inputAddress = addr_q;
  assign bus.sdram_writeData    = wdata_q;
  assign bus.sdram_isWriting    = wr_q;
  assign bus.sdram_inputValid   = valid_q;
  assign bus.outputAudio        = audio_q;
endmodule
